// File: rtl/cpu_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_if
// Host/debug and CPU-side signal bundle for the run/halt/step sequencer.
//   master : host/CPU-top side. Drives the requests, breakpoint setup,
//            PC_OUT and HLT_DEC, and observes the sequencer outputs.
//   slave  : cpu_run_ctrl side.
// Signals:
//   RUN_REQ/HALT_REQ/STEP_REQ : one-cycle request pulses
//   BP_EN/BP_ADDR             : instruction breakpoint enable and address
//   PC_OUT/HLT_DEC            : current PC and "HALT opcode at PC" flag
//   PC_RST/PC_EN/WR_EN        : PC reset, PC advance and write qualifier
//   STATE/BP_HIT/STEP_DONE    : status outputs
//   INSTR_CNT                 : retired-instruction count
// -----------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
  parameter int AWIDTH    = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 RUN_REQ;
  logic                 HALT_REQ;
  logic                 STEP_REQ;
  logic                 BP_EN;
  logic [AWIDTH-1:0]    BP_ADDR;
  logic [AWIDTH-1:0]    PC_OUT;
  logic                 HLT_DEC;
  logic                 PC_RST;
  logic                 PC_EN;
  logic                 WR_EN;
  logic [2:0]           STATE;
  logic                 BP_HIT;
  logic                 STEP_DONE;
  logic [CNT_WIDTH-1:0] INSTR_CNT;

  modport master (
    output RUN_REQ, HALT_REQ, STEP_REQ, BP_EN, BP_ADDR, PC_OUT, HLT_DEC,
    input  PC_RST, PC_EN, WR_EN, STATE, BP_HIT, STEP_DONE, INSTR_CNT
  );

  modport slave (
    input  RUN_REQ, HALT_REQ, STEP_REQ, BP_EN, BP_ADDR, PC_OUT, HLT_DEC,
    output PC_RST, PC_EN, WR_EN, STATE, BP_HIT, STEP_DONE, INSTR_CNT
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/halt/single-step sequencer for the one-cycle CPU core. Owns the PC
// reset and PC advance enable, gates every architectural write through
// WR_EN, and provides a single-address instruction breakpoint.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : cpu_run_ctrl_if.slave (requests, breakpoint, PC/decoder inputs,
//          PC_RST/PC_EN/WR_EN, STATE, BP_HIT, STEP_DONE, INSTR_CNT)
// Optional feature: define CPU_CTRL_INSTR_CNT_EN to build the saturating
// retired-instruction counter; otherwise INSTR_CNT is tied to zero.
// STATE encoding: INIT=0, HALTED=1, RUN=2, STEP=3, BREAK=4.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int AWIDTH    = 8,
  parameter int RST_HOLD  = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic           CLK,
  input logic           RST,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_HALTED = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic        pc_rst_q, pc_rst_d;
  logic        bp_hit_q, bp_hit_d;
  logic        step_done_q, step_done_d;
  logic        armed_q, armed_d;
  logic        exec;
  logic [AWIDTH-1:0] pc_cur;
  logic        bp_match;

  assign pc_cur   = bus.PC_OUT;
  assign bp_match = bus.BP_EN && armed_q && (pc_cur == bus.BP_ADDR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_INIT;
      hold_q      <= HOLD_INIT;
      pc_rst_q    <= 1'b1;
      bp_hit_q    <= 1'b0;
      step_done_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      pc_rst_q    <= pc_rst_d;
      bp_hit_q    <= bp_hit_d;
      step_done_q <= step_done_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    pc_rst_d    = 1'b0;
    bp_hit_d    = bp_hit_q;
    step_done_d = 1'b0;
    armed_d     = armed_q;
    exec        = 1'b0;

    case (state_q)
      S_INIT: begin
        // Hold counter starts at RST_HOLD-1, so PC_RST stays high across
        // exactly RST_HOLD edges after reset release.
        if (hold_q == 4'd0) begin
          state_d = S_HALTED;
        end else begin
          hold_d   = hold_q - 4'd1;
          pc_rst_d = 1'b1;
        end
      end

      S_HALTED, S_BREAK: begin
        if (bus.STEP_REQ) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end else if (bus.RUN_REQ) begin
          state_d  = S_RUN;
          bp_hit_d = 1'b0;
          // Disarmed for the first RUN cycle so a resume from the
          // breakpoint address executes instead of re-trapping.
          armed_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (bus.HALT_REQ || bus.HLT_DEC) begin
          state_d = S_HALTED;
        end else if (bp_match) begin
          state_d  = S_BREAK;
          bp_hit_d = 1'b1;
        end else begin
          exec    = 1'b1;
          armed_d = 1'b1;
        end
      end

      S_STEP: begin
        // STEP_DONE reports completion even when the step was blocked.
        state_d     = S_HALTED;
        step_done_d = 1'b1;
        exec        = !(bus.HALT_REQ || bus.HLT_DEC);
      end

      default: state_d = S_HALTED;
    endcase
  end

  assign bus.PC_RST    = pc_rst_q;
  assign bus.PC_EN     = exec;
  assign bus.WR_EN     = exec;
  assign bus.STATE     = state_q;
  assign bus.BP_HIT    = bp_hit_q;
  assign bus.STEP_DONE = step_done_q;

`ifdef CPU_CTRL_INSTR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating count of execute cycles; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (exec && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.INSTR_CNT = cnt_q;
`else
  assign bus.INSTR_CNT = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. Stimulus pushes the expected per-cycle
// response into a scoreboard queue tagged with its cycle number; a monitor
// on the falling edge pops and compares. A small PC model stands in for
// cpu_pc and follows PC_RST/PC_EN; HLT_DEC is decoded from that PC.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int AW = 8;
  localparam int CW = 16;
`ifdef CPU_CTRL_INSTR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic CLK;
  logic RST;

  cpu_run_ctrl_if #(.AWIDTH(AW), .CNT_WIDTH(CW)) bus ();

  cpu_run_ctrl #(.AWIDTH(AW), .RST_HOLD(4), .CNT_WIDTH(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment model: PC register and HALT-opcode decoder.
  logic [AW-1:0] pc_m;
  logic          hlt_on;
  logic [AW-1:0] hlt_addr;

  always @(posedge CLK or negedge RST) begin
    if (!RST)            pc_m <= '0;
    else if (bus.PC_RST) pc_m <= '0;
    else if (bus.PC_EN)  pc_m <= pc_m + 1'b1;
  end

  assign bus.PC_OUT  = pc_m;
  assign bus.HLT_DEC = hlt_on && (pc_m == hlt_addr);

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    string         nm;
    logic [2:0]    st;
    bit            en;
    bit            pr;
    bit            bp;
    bit            sd;
    logic [AW-1:0] pc;
    logic [CW-1:0] cnt;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s cycle=%0d actual=%0h required=%0h", nm, fld, cyc, act, req);
    end
  endtask

  // Monitor: compare every expectation stamped with the current cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item_t it;
      it = sb.pop_front();
      if (it.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s stale expectation cycle=%0d now=%0d", it.nm, it.cyc, cyc);
      end else begin
        chk(it.nm, "STATE",     32'(bus.STATE),     32'(it.st));
        chk(it.nm, "PC_EN",     32'(bus.PC_EN),     32'(it.en));
        chk(it.nm, "WR_EN",     32'(bus.WR_EN),     32'(it.en));
        chk(it.nm, "PC_RST",    32'(bus.PC_RST),    32'(it.pr));
        chk(it.nm, "BP_HIT",    32'(bus.BP_HIT),    32'(it.bp));
        chk(it.nm, "STEP_DONE", 32'(bus.STEP_DONE), 32'(it.sd));
        chk(it.nm, "INSTR_CNT", 32'(bus.INSTR_CNT), 32'(it.cnt));
        chk(it.nm, "PC",        32'(pc_m),          32'(it.pc));
        $display("txn %s cycle=%0d state=%0d pc=%0h en=%0b", it.nm, it.cyc,
                 bus.STATE, pc_m, bus.PC_EN);
      end
    end
  end

  // Expected response for the current cycle.
  task automatic exp_c(input string nm, input logic [2:0] st, input bit en,
                       input bit pr, input bit bp, input bit sd, input logic [AW-1:0] pc);
    item_t it;
    it.cyc = cyc;
    it.nm  = nm;
    it.st  = st;
    it.en  = en;
    it.pr  = pr;
    it.bp  = bp;
    it.sd  = sd;
    it.pc  = pc;
    it.cnt = CNT_ON ? exp_cnt : '0;
    sb.push_back(it);
    if (en && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Hold reset one cycle, release, then expect 4 INIT cycles with PC_RST.
  task automatic do_reset(input bit run_during_init);
    RST = 1'b0;
    exp_cnt = '0;
    exp_c("rst_hold", 3'd0, 0, 1, 0, 0, 8'h00);
    tick();
    RST = 1'b1;
    bus.RUN_REQ = run_during_init;
    for (int i = 0; i < 4; i++) begin
      exp_c("init", 3'd0, 0, 1, 0, 0, 8'h00);
      tick();
    end
    bus.RUN_REQ = 1'b0;
    exp_c("init_done", 3'd1, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST          = 1'b0;
    bus.RUN_REQ  = 1'b0;
    bus.HALT_REQ = 1'b0;
    bus.STEP_REQ = 1'b0;
    bus.BP_EN    = 1'b0;
    bus.BP_ADDR  = '0;
    hlt_on       = 1'b0;
    hlt_addr     = '0;
    tick();

    // Reset release; RUN_REQ during INIT must be ignored.
    do_reset(1'b1);

    // Single step at PC 0.
    bus.STEP_REQ = 1'b1; tick(); bus.STEP_REQ = 1'b0;
    exp_c("step_exec", 3'd3, 1, 0, 0, 0, 8'h00); tick();
    exp_c("step_done", 3'd1, 0, 0, 0, 1, 8'h01); tick();
    bus.HALT_REQ = 1'b1;
    exp_c("halted_idle", 3'd1, 0, 0, 0, 0, 8'h01); tick();
    bus.HALT_REQ = 1'b0;

    // Run into breakpoint at 0x05, then resume through it.
    bus.BP_EN = 1'b1; bus.BP_ADDR = 8'h05; bus.RUN_REQ = 1'b1;
    exp_c("halt_ignored", 3'd1, 0, 0, 0, 0, 8'h01); tick();
    bus.RUN_REQ = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      exp_c("run_exec", 3'd2, 1, 0, 0, 0, AW'(p)); tick();
    end
    exp_c("bp_block", 3'd2, 0, 0, 0, 0, 8'h05); tick();
    bus.RUN_REQ = 1'b1;
    exp_c("bp_break", 3'd4, 0, 0, 1, 0, 8'h05); tick();
    bus.RUN_REQ = 1'b0;
    exp_c("bp_resume", 3'd2, 1, 0, 0, 0, 8'h05); tick();
    exp_c("run_exec6", 3'd2, 1, 0, 0, 0, 8'h06); tick();
    bus.HALT_REQ = 1'b1;
    exp_c("halt_req", 3'd2, 0, 0, 0, 0, 8'h07); tick();
    bus.HALT_REQ = 1'b0;

    // HALT opcode at 0x09 stops the run without executing it.
    bus.BP_EN = 1'b0; hlt_addr = 8'h09; hlt_on = 1'b1; bus.RUN_REQ = 1'b1;
    exp_c("halted7", 3'd1, 0, 0, 0, 0, 8'h07); tick();
    bus.RUN_REQ = 1'b0;
    exp_c("run_exec7", 3'd2, 1, 0, 0, 0, 8'h07); tick();
    exp_c("run_exec8", 3'd2, 1, 0, 0, 0, 8'h08); tick();
    exp_c("hlt_dec", 3'd2, 0, 0, 0, 0, 8'h09); tick();
    bus.RUN_REQ = 1'b1;
    exp_c("hlt_halted", 3'd1, 0, 0, 0, 0, 8'h09); tick();
    bus.RUN_REQ = 1'b0;

    // HALT_REQ and HLT_DEC together in RUN.
    bus.HALT_REQ = 1'b1;
    exp_c("halt_and_hlt", 3'd2, 0, 0, 0, 0, 8'h09); tick();
    bus.HALT_REQ = 1'b0;

    // STEP_REQ and RUN_REQ together: STEP wins; HLT_DEC blocks the step.
    bus.STEP_REQ = 1'b1; bus.RUN_REQ = 1'b1;
    exp_c("halted9", 3'd1, 0, 0, 0, 0, 8'h09); tick();
    bus.STEP_REQ = 1'b0; bus.RUN_REQ = 1'b0;
    exp_c("step_blocked", 3'd3, 0, 0, 0, 0, 8'h09); tick();
    hlt_on = 1'b0; bus.RUN_REQ = 1'b1;
    exp_c("step_blk_done", 3'd1, 0, 0, 0, 1, 8'h09); tick();
    bus.RUN_REQ = 1'b0;

    // Asynchronous reset in the middle of RUN.
    exp_c("run_exec9", 3'd2, 1, 0, 0, 0, 8'h09); tick();
    exp_c("run_exec10", 3'd2, 1, 0, 0, 0, 8'h0a); tick();
    #1;
    RST = 1'b0;
    exp_cnt = '0;
    exp_c("async_rst", 3'd0, 0, 1, 0, 0, 8'h00);
    tick();
    do_reset(1'b0);

    // Reset during an in-flight step: no STEP_DONE afterwards.
    bus.STEP_REQ = 1'b1; tick(); bus.STEP_REQ = 1'b0;
    #1;
    RST = 1'b0;
    exp_cnt = '0;
    exp_c("step_rst", 3'd0, 0, 1, 0, 0, 8'h00);
    tick();
    do_reset(1'b0);
    tick();
    exp_c("post_rst_idle", 3'd1, 0, 0, 0, 0, 8'h00);
    tick();
    tick();

    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s unchecked expectation cycle=%0d", it.nm, it.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/halt/single-step sequencer for the one-cycle CPU core.
- Owns PC reset and PC advance enable.
- Qualifies all architectural write enables (register file, data memory, accumulator) through one WR_EN gate.
- Provides a single-address instruction breakpoint.
- Sits beside cpu_pc/cpu_id at CPU top level; driven by a debug/host interface through pulse requests.

Parameters:
AWIDTH, 8, instruction address width (matches PC_OUT width)
RST_HOLD, 4, cycles PC_RST is held after reset release (legal range 1..15)
CNT_WIDTH, 16, retired-instruction counter width

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
RUN_REQ  input  1  one-cycle pulse: start free-running execution
HALT_REQ  input  1  one-cycle pulse: stop execution
STEP_REQ  input  1  one-cycle pulse: execute exactly one instruction
BP_EN  input  1  breakpoint enable
BP_ADDR  input  AWIDTH  breakpoint instruction address
PC_OUT  input  AWIDTH  current PC value from cpu_pc
HLT_DEC  input  1  decoder flag: instruction at PC_OUT is HALT opcode
PC_RST  output  1  synchronous reset request to cpu_pc
PC_EN  output  1  PC advance/load enable for this cycle
WR_EN  output  1  global qualifier ANDed into EN_REG_F/EN_D_MEM/EN_ACC
STATE  output  3  current state encoding
BP_HIT  output  1  sticky breakpoint-hit flag
STEP_DONE  output  1  one-cycle pulse after a step completes
INSTR_CNT  output  CNT_WIDTH  retired-instruction count (see Optional Feature)

Behaviour:
- States, with STATE encoding: INIT=0, HALTED=1, RUN=2, STEP=3, BREAK=4. Unused codes recover to HALTED on the next edge.
- Reset (RST=0, asynchronous) drives:
  - state INIT; hold counter = RST_HOLD-1; PC_RST=1.
  - BP_HIT=0, STEP_DONE=0, armed flag=0, INSTR_CNT=0.
- INIT:
  - PC_RST=1 for exactly RST_HOLD rising edges after RST goes high, then HALTED.
  - All requests ignored.
- Execute cycle: PC_EN=WR_EN=1, combinational from state and inputs. Only RUN and STEP may execute. PC_EN=WR_EN=0 in every other state.
- Blocking conditions, in priority order, evaluated in RUN/STEP. Any of them suppresses execution in that same cycle (PC_EN=WR_EN=0):
  1. HALT_REQ: next state HALTED.
  2. HLT_DEC: next state HALTED. The HALT instruction is never executed and PC stays on it.
  3. Breakpoint, RUN only, requires BP_EN & armed & PC_OUT==BP_ADDR: next state BREAK, BP_HIT<=1.
- armed flag:
  - Cleared on entry to RUN.
  - Set after the first execute cycle in RUN.
  - Effect: resuming from a breakpoint address executes that instruction instead of re-trapping.
- RUN: stays RUN while executing.
- STEP:
  - Lasts exactly one cycle, then HALTED.
  - STEP_DONE=1 on the following cycle, whether the instruction executed or was blocked by HALT_REQ/HLT_DEC.
  - Breakpoints are never checked in STEP.
- HALTED/BREAK:
  - STEP_REQ goes to STEP; RUN_REQ goes to RUN.
  - STEP_REQ wins if both are asserted in the same cycle.
  - HALT_REQ is ignored.
  - An accepted request clears BP_HIT.
- PC_RST is registered. STEP_DONE is a registered single-cycle pulse. PC_EN/WR_EN are combinational, with no extra latency.
- Latency:
  - RUN_REQ in cycle n gives the first execute in cycle n+1.
  - HALT_REQ in cycle n suppresses cycle n.
- Reset mid-operation: immediate return to INIT. An in-flight step produces no STEP_DONE.

Optional Feature:
- Macro: CPU_CTRL_INSTR_CNT_EN.
- Defined:
  - INSTR_CNT increments by 1 on every execute cycle.
  - Saturates at all-ones.
  - Cleared only by reset.
- Undefined:
  - No counter logic.
  - INSTR_CNT tied to 0; port list unchanged.

Test Plan:
- Reset release with RST_HOLD=4 -> PC_RST=1 for 4 edges, STATE=1, PC_EN=0; RUN_REQ asserted during INIT is ignored.
- HALTED, STEP_REQ pulse at PC=0x00 -> STATE=3 for one cycle with PC_EN=WR_EN=1, then STATE=1; STEP_DONE=1 one cycle later; PC=0x01; INSTR_CNT=1 with macro.
- RUN from PC=0x00, BP_EN=1, BP_ADDR=0x05 -> 5 execute cycles; at PC=0x05 PC_EN=0, STATE=4, BP_HIT=1. RUN_REQ then executes 0x05 without re-trap and clears BP_HIT.
- RUN with HLT_DEC=1 at PC=0x03 -> cycle with PC=0x03 has WR_EN=0; STATE=1; PC holds 0x03.
- RUN, HALT_REQ and HLT_DEC in same cycle -> HALTED, no execute; STEP_REQ and RUN_REQ together in HALTED -> STATE=3.
- RST low mid-RUN -> asynchronous return to STATE=0, PC_RST=1, BP_HIT=0, INSTR_CNT=0; with the macro undefined, INSTR_CNT stays 0 throughout.
